mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-outstanding memory port between an instruction-fetch port
// and a data port. Ties are broken round robin, with fetch winning the first
// tie after reset. An access that sees no mem_ack within TIMEOUT busy cycles
// is abandoned. The abandoned access is still acknowledged, with err high and
// read data 16'hFFFF.
//
// Ports
//   clk, reset          core clock; asynchronous active-high reset
//   if_req/if_addr      fetch request and address (held until if_ack)
//   if_rdata/if_ack     fetch read data and one-cycle completion pulse
//   d_req/d_we/d_addr   data request, write enable and address
//   d_wdata             data write value
//   d_rdata/d_ack       data read value and one-cycle completion pulse
//   err                 qualifies an ack that ended by timeout
//   mem_req/mem_we      memory strobe (whole access) and write enable
//   mem_addr/mem_wdata  memory address and write data
//   mem_rdata/mem_ack   memory read data and completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;     // 1 = data port was granted most recently
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;

    logic        if_elig_s;
    logic        d_elig_s;
    logic        timeout_s;

    // A requester whose ack is showing this cycle is still holding req from
    // the access that just finished, so it must not be granted again.
    assign if_elig_s = if_req & ~if_ack_q;
    assign d_elig_s  = d_req & ~d_ack_q;

    // This busy cycle is the TIMEOUT-th one; counter cannot pass 254 here.
    assign timeout_s = ((cnt_q + 8'd1) == TIMEOUT_C);

    // Next-state, grant, completion and timeout decisions.
    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Fetch wins when it is alone, or on a tie after a data grant.
                if (if_elig_s && (!d_elig_s || last_d_q)) begin
                    state_d  = ST_IF_BUSY;
                    last_d_d = 1'b0;
                    cnt_d    = 8'd0;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = 16'h0000;
                end else if (d_elig_s) begin
                    state_d  = ST_D_BUSY;
                    last_d_d = 1'b1;
                    cnt_d    = 8'd0;
                    addr_d   = d_addr;
                    we_d     = d_we;
                    wdata_d  = d_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IF_BUSY, ST_D_BUSY: begin
                // mem_ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    if (state_q == ST_IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = 16'hFFFF;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = 16'hFFFF;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_d_q   <= 1'b1;
            cnt_q      <= 8'd0;
            addr_q     <= 16'h0000;
            we_q       <= 1'b0;
            wdata_q    <= 16'h0000;
            if_rdata_q <= 16'h0000;
            d_rdata_q  <= 16'h0000;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
        end
    end

    // mem_req is a pure decode of the state register.
    assign mem_req   = (state_q != ST_IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scenario tasks for mem_arbiter. A transaction-level reference model holds
// the round-robin winner and each port's expected read data. The memory side
// is emulated by the bench with a chosen latency per access.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: who was granted last, and each port's read data.
    bit          mdl_last_d;
    logic [15:0] mdl_if_rdata;
    logic [15:0] mdl_d_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic model_reset();
        mdl_last_d   = 1'b1;
        mdl_if_rdata = 16'h0000;
        mdl_d_rdata  = 16'h0000;
    endtask

    // One access from grant to ack. The memory acks in busy cycle lat,
    // or never if lat exceeds TO.
    task automatic serve(input bit is_d, input logic [15:0] addr, input bit we,
                         input logic [15:0] wdata, input int lat,
                         input logic [15:0] mdata, input string tag);
        int  n = 0;
        bit  done = 1'b0;
        bit  exp_err;
        int  exp_n;
        exp_err = (lat > TO);
        exp_n   = exp_err ? TO : lat;
        for (int c = 0; c < TO + 10 && !done; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                n++;
                if (n == 1) begin
                    checks++;
                    if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata)) begin
                        errors++;
                        $display("FAIL %s bus: addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                                 tag, mem_addr, mem_we, mem_wdata, addr, we, wdata);
                    end
                end
                if (n == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'($urandom);
                end
            end else if (n > 0) begin
                done    = 1'b1;
                mem_ack = 1'b0;
                if (is_d) begin
                    if (exp_err) mdl_d_rdata = 16'hFFFF;
                    else if (!we) mdl_d_rdata = mdata;
                end else begin
                    if (exp_err) mdl_if_rdata = 16'hFFFF;
                    else mdl_if_rdata = mdata;
                end
                mdl_last_d = is_d;
                checks++;
                if (if_ack !== !is_d || d_ack !== is_d || err !== exp_err) begin
                    errors++;
                    $display("FAIL %s ack: if_ack=%b d_ack=%b err=%b, want if_ack=%b d_ack=%b err=%b",
                             tag, if_ack, d_ack, err, !is_d, is_d, exp_err);
                end
                checks++;
                if (n != exp_n) begin
                    errors++;
                    $display("FAIL %s busy_cycles: got %0d, want %0d", tag, n, exp_n);
                end
                checks++;
                if (if_rdata !== mdl_if_rdata || d_rdata !== mdl_d_rdata) begin
                    errors++;
                    $display("FAIL %s rdata: if=%h d=%h, want if=%h d=%h",
                             tag, if_rdata, d_rdata, mdl_if_rdata, mdl_d_rdata);
                end
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s no_completion: mem_req=%b after %0d busy cycles, want ack", tag, mem_req, n);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_ack, d_ack, err, mem_req, mem_we} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: if_ack,d_ack,err,mem_req,mem_we=%b, want 00000",
                     {if_ack, d_ack, err, mem_req, mem_we});
        end
        checks++;
        if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || if_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h, want all 0000",
                     mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_fetch_basic();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0400;
        serve(1'b0, 16'h0400, 1'b0, 16'h0000, 1, 16'hA5A5, "fetch_basic");
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_regrant: mem_req=%b, want 0", mem_req);
        end
    endtask

    task automatic test_tie();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'hFFFE; d_wdata = 16'h1234;
        serve(1'b0, 16'h0100, 1'b0, 16'h0000, 2, 16'h1111, "tie_first_fetch");
        @(posedge clk); #1;
        if_req = 1'b0;
        serve(1'b1, 16'hFFFE, 1'b1, 16'h1234, 3, 16'h2222, "tie_then_data");
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        serve(1'b0, 16'h0200, 1'b0, 16'h0000, 1, 16'h3333, "tie_again_fetch");
        @(posedge clk); #1;
        if_req = 1'b0;
        serve(1'b1, 16'h0300, 1'b0, 16'h0000, 1, 16'h4444, "tie_again_data");
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_timeout();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0777;
        serve(1'b1, 16'h0777, 1'b0, 16'h0000, TO + 5, 16'h0000, "timeout");
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_ack_at_timeout();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0888;
        serve(1'b1, 16'h0888, 1'b0, 16'h0000, TO, 16'h5A5A, "ack_at_timeout");
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0999; d_wdata = 16'hCAFE;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({if_ack, d_ack, err, mem_req, mem_we} !== 5'b00000 ||
            mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || d_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_outputs: ctrl=%b addr=%h wdata=%h d_rdata=%h, want all 0",
                     {if_ack, d_ack, err, mem_req, mem_we}, mem_addr, mem_wdata, d_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0; d_req = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (d_ack !== 1'b0 || if_ack !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_no_ack: activity seen after release, want none");
        end
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0AAA;
        serve(1'b1, 16'h0AAA, 1'b0, 16'h0000, 2, 16'h6006, "after_reset_mid");
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic test_stray_ack();
        bit bad = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_ack !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0 ||
                if_rdata !== mdl_if_rdata || d_rdata !== mdl_d_rdata) bad = 1'b1;
        end
        mem_ack = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stray_ack: idle state disturbed by mem_ack, want no change");
        end
    endtask

    task automatic test_random();
        logic [1:0]  mode;
        logic [15:0] fa, da, dw, mf, md;
        bit          dwe, first_d;
        int          lf, ld;
        for (int it = 0; it < 40; it++) begin
            mode = 2'($urandom_range(1, 3));
            fa = 16'($urandom); da = 16'($urandom); dw = 16'($urandom);
            mf = 16'($urandom); md = 16'($urandom);
            dwe = 1'($urandom);
            lf = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(1, TO));
            ld = ($urandom_range(0, 7) == 0) ? TO + 2 : int'($urandom_range(1, TO));
            @(posedge clk); #1;
            if_req = mode[0]; if_addr = fa;
            d_req = mode[1]; d_we = dwe; d_addr = da; d_wdata = dw;
            first_d = (mode == 2'b10) ? 1'b1 : ((mode == 2'b01) ? 1'b0 : !mdl_last_d);
            if (first_d) serve(1'b1, da, dwe, dw, ld, md, "rand_d");
            else serve(1'b0, fa, 1'b0, 16'h0000, lf, mf, "rand_if");
            @(posedge clk); #1;
            if (first_d) d_req = 1'b0; else if_req = 1'b0;
            if (mode == 2'b11) begin
                if (first_d) serve(1'b0, fa, 1'b0, 16'h0000, lf, mf, "rand_if2");
                else serve(1'b1, da, dwe, dw, ld, md, "rand_d2");
                @(posedge clk); #1;
                if_req = 1'b0; d_req = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle: mem_req=%b, want 0", mem_req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_reset();
        test_tie();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_stray_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
